// File: rtl/seg_readback_pkg.sv
// ============================================================================
// Module      : seg_readback_pkg
// Description : Shared constants and types for the seven-segment readback block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_readback_pkg;

    // Active-high segment patterns, bit6=a ... bit0=g
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    localparam logic [3:0] BCD_INVALID = 4'hF;
    localparam logic [3:0] BCD_BLANK   = 4'hA;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_decode.sv
// ============================================================================
// Module      : seg_pattern_decode
// Description : Combinational active-high segment pattern to BCD decoder.
//               SEG_READBACK_BLANK_EN makes the all-off pattern a valid blank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_pattern_decode
    import seg_readback_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_err
);

    always_comb begin
        o_bcd = BCD_INVALID;
        o_err = 1'b1;
        case (i_seg)
            SEG_0: begin o_bcd = 4'd0; o_err = 1'b0; end
            SEG_1: begin o_bcd = 4'd1; o_err = 1'b0; end
            SEG_2: begin o_bcd = 4'd2; o_err = 1'b0; end
            SEG_3: begin o_bcd = 4'd3; o_err = 1'b0; end
            SEG_4: begin o_bcd = 4'd4; o_err = 1'b0; end
            SEG_5: begin o_bcd = 4'd5; o_err = 1'b0; end
            SEG_6: begin o_bcd = 4'd6; o_err = 1'b0; end
            SEG_7: begin o_bcd = 4'd7; o_err = 1'b0; end
            SEG_8: begin o_bcd = 4'd8; o_err = 1'b0; end
            SEG_9: begin o_bcd = 4'd9; o_err = 1'b0; end
`ifdef SEG_READBACK_BLANK_EN
            7'b0000000: begin o_bcd = BCD_BLANK; o_err = 1'b0; end
`endif
            default: begin o_bcd = BCD_INVALID; o_err = 1'b1; end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_readback.sv
// ============================================================================
// Module      : seg_readback
// Description : Samples a multiplexed active-low 7-seg bus, debounces each
//               digit and presents whole frames of BCD on valid/ready.
//               Optional macro: SEG_READBACK_BLANK_EN (blank digit decode).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_readback
    import seg_readback_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    digit_accept
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_prev_seg;
    logic [NUM_DIGITS-1:0]   r_prev_an;
    logic [CNT_W-1:0]        r_run;
    logic [4*NUM_DIGITS-1:0] r_cap_bcd;
    logic [NUM_DIGITS-1:0]   r_cap_err;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic                    r_accept;
    logic [4*NUM_DIGITS-1:0] r_frame_bcd;
    logic [NUM_DIGITS-1:0]   r_frame_err;
    state_t                  r_state;

    logic [NUM_DIGITS-1:0]   w_an_act;
    logic                    w_valid;
    logic                    w_same;
    logic [CNT_W-1:0]        w_run_nxt;
    logic                    w_accept;
    logic [NUM_DIGITS-1:0]   w_acc_bits;
    logic [3:0]              w_bcd;
    logic                    w_err;
    state_t                  w_state_nxt;
    logic                    w_load_frame;
    logic                    w_clear_mask;

    // Input stage: pins registered once, everything else works on r_seg/r_an
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= '0;
            r_an  <= '0;
        end else begin
            r_seg <= seg_n;
            r_an  <= an_n;
        end
    end

    assign w_an_act = ~r_an;
    assign w_valid  = $onehot(w_an_act);
    assign w_same   = (r_an == r_prev_an) && (r_seg == r_prev_seg);

    always_comb begin
        w_run_nxt = r_run;
        if (!w_valid) begin
            w_run_nxt = '0;
        end else if (!w_same) begin
            w_run_nxt = CNT_W'(1);
        end else if (r_run != CNT_MAX) begin
            w_run_nxt = r_run + CNT_W'(1);
        end
    end

    // Fires only on the step into STABLE_CYCLES; saturation blocks repeats
    assign w_accept   = w_valid && w_same && (r_run == CNT_LAST);
    assign w_acc_bits = w_accept ? w_an_act : '0;

    seg_pattern_decode u_decode (
        .i_seg (~r_seg),
        .o_bcd (w_bcd),
        .o_err (w_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_seg <= '0;
            r_prev_an  <= '0;
            r_run      <= '0;
            r_accept   <= 1'b0;
            r_cap_bcd  <= '0;
            r_cap_err  <= '0;
        end else begin
            r_run    <= w_run_nxt;
            r_accept <= w_accept;
            if (w_valid) begin
                r_prev_seg <= r_seg;
                r_prev_an  <= r_an;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_acc_bits[i]) begin
                    r_cap_bcd[4*i +: 4] <= w_bcd;
                    r_cap_err[i]        <= w_err;
                end
            end
        end
    end

    // A handshake clears the mask first so a same-cycle accept counts for the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (w_clear_mask) begin
            r_mask <= w_acc_bits;
        end else begin
            r_mask <= r_mask | w_acc_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (&r_mask)     w_state_nxt = PRESENT;
            PRESENT: if (frame_ready) w_state_nxt = COLLECT;
            default:                  w_state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        w_load_frame = (r_state == COLLECT) && (&r_mask);
        w_clear_mask = (r_state == PRESENT) && frame_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_bcd <= '0;
            r_frame_err <= '0;
        end else if (w_load_frame) begin
            r_frame_bcd <= r_cap_bcd;
            r_frame_err <= r_cap_err;
        end
    end

    assign frame_valid  = (r_state == PRESENT);
    assign frame_bcd    = r_frame_bcd;
    assign frame_err    = r_frame_err;
    assign digit_accept = r_accept;

endmodule

`default_nettype wire

// File: tb/tb_seg_readback.sv
// ============================================================================
// Module      : tb_seg_readback
// Description : Randomised scoreboard bench for seg_readback (4 digits, 4-cycle dwell).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_readback;

    localparam int N = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [6:0]     seg_n;
    logic [N-1:0]   an_n;
    logic           frame_valid;
    logic           frame_ready;
    logic [4*N-1:0] frame_bcd;
    logic [N-1:0]   frame_err;
    logic           digit_accept;

    seg_readback #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_n        (seg_n),
        .an_n         (an_n),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_bcd    (frame_bcd),
        .frame_err    (frame_err),
        .digit_accept (digit_accept)
    );

    always #5 clk = ~clk;

    typedef struct { int dig; logic [3:0] bcd; logic err; } acc_t;
    typedef struct { logic [4*N-1:0] bcd; logic [N-1:0] err; } frame_t;

    logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    int       cyc = 0;
    int       n_cmp = 0;
    int       n_bad = 0;
    acc_t     acc_at [int];
    frame_t   fq [$];
    int       rdy_mode = 1;
    int       prev_an = -1;
    logic [6:0] prev_pat = '0;

    logic [3:0] m_bcd [N];
    logic       m_err [N];
    bit         m_got [N];
    bit         m_pres = 1'b0;
    bit         e_acc = 1'b0;
    bit         e_rst = 1'b0;
    bit         last_pres = 1'b0;

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] b, output logic e);
        b = 4'hF;
        e = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (PAT[i] == p) begin
                b = i[3:0];
                e = 1'b0;
            end
        end
`ifdef SEG_READBACK_BLANK_EN
        if (p == 7'b0000000) begin
            b = 4'hA;
            e = 1'b0;
        end
`endif
    endfunction

    // Digit an (0..N-1), -1 = no anode active, -2 = all anodes active
    task automatic dwell(input int an, input logic [6:0] pat, input int len);
        acc_t a;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            if (j == 0) begin
                rst = 1'b0;
                if (an >= 0 && len >= S) begin
                    ref_decode(pat, a.bcd, a.err);
                    a.dig = an;
                    acc_at[cyc + 1 + S] = a;
                end
            end
            seg_n = ~pat;
            if (an == -1)      an_n = '1;
            else if (an == -2) an_n = '0;
            else               an_n = ~(N'(1) << an);
            if (rdy_mode == 2) frame_ready = 1'($urandom_range(0, 1));
            else               frame_ready = (rdy_mode == 1);
        end
        prev_an  = an;
        prev_pat = pat;
    endtask

    task automatic do_reset(input int len);
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            rst   = 1'b1;
            an_n  = '0;
            seg_n = 7'($urandom);
        end
        prev_an = -1;
    endtask

    task automatic frame4(input logic [6:0] p0, input logic [6:0] p1,
                          input logic [6:0] p2, input logic [6:0] p3);
        dwell(0, p0, 6);
        dwell(1, p1, 6);
        dwell(2, p2, 6);
        dwell(3, p3, 6);
        dwell(-1, 7'h00, 4);
    endtask

    // Reference model: frame assembly from accepted digits and handshakes
    initial begin
        acc_t   a;
        frame_t f;
        bit     all;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            e_rst = rst;
            e_acc = 1'b0;
            if (rst) begin
                m_pres = 1'b0;
                for (int i = 0; i < N; i++) begin
                    m_bcd[i] = 4'h0;
                    m_err[i] = 1'b0;
                    m_got[i] = 1'b0;
                end
                acc_at.delete();
                fq.delete();
            end else begin
                all = 1'b1;
                for (int i = 0; i < N; i++) if (!m_got[i]) all = 1'b0;
                if (m_pres) begin
                    if (frame_ready) begin
                        m_pres = 1'b0;
                        for (int i = 0; i < N; i++) m_got[i] = 1'b0;
                    end
                end else if (all) begin
                    for (int i = 0; i < N; i++) begin
                        f.bcd[4*i +: 4] = m_bcd[i];
                        f.err[i]        = m_err[i];
                    end
                    fq.push_back(f);
                    m_pres = 1'b1;
                end
                if (acc_at.exists(cyc)) begin
                    a = acc_at[cyc];
                    acc_at.delete(cyc);
                    m_bcd[a.dig] = a.bcd;
                    m_err[a.dig] = a.err;
                    m_got[a.dig] = 1'b1;
                    e_acc = 1'b1;
                end
            end
        end
    end

    // Monitor: pops a frame once its handshake completed and compares outputs
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!e_rst && last_pres && frame_ready && fq.size() > 0) void'(fq.pop_front());
            n_cmp++;
            if (digit_accept !== e_acc) begin
                n_bad++;
                $display("FAIL accept cyc=%0d got=%b exp=%b", cyc, digit_accept, e_acc);
            end
            n_cmp++;
            if (frame_valid !== m_pres) begin
                n_bad++;
                $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, frame_valid, m_pres);
            end
            if (e_rst) begin
                n_cmp++;
                if (frame_bcd !== '0 || frame_err !== '0) begin
                    n_bad++;
                    $display("FAIL reset_frame cyc=%0d got=%h/%b exp=0/0", cyc, frame_bcd, frame_err);
                end
            end
            if (m_pres) begin
                n_cmp++;
                if (fq.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_q cyc=%0d got=%h/%b exp=none", cyc, frame_bcd, frame_err);
                end else if (frame_bcd !== fq[0].bcd || frame_err !== fq[0].err) begin
                    n_bad++;
                    $display("FAIL frame cyc=%0d got=%h/%b exp=%h/%b",
                             cyc, frame_bcd, frame_err, fq[0].bcd, fq[0].err);
                end
            end
            last_pres = m_pres;
        end
    end

    initial begin
        int         an;
        logic [6:0] pat;
        rst = 1'b1;
        an_n = '1;
        seg_n = '1;
        frame_ready = 1'b0;
        do_reset(3);

        // Digits 1,2,3,4 -> frame 16'h4321
        rdy_mode = 1;
        frame4(PAT[1], PAT[2], PAT[3], PAT[4]);

        // Digit 2 too short: no frame until a long dwell arrives
        dwell(0, PAT[5], 6);
        dwell(1, PAT[6], 6);
        dwell(2, PAT[7], 3);
        dwell(3, PAT[8], 6);
        dwell(-1, 7'h00, 6);
        dwell(2, PAT[7], 5);
        dwell(-1, 7'h00, 4);

        // Unrecognised pattern on digit 1
        frame4(PAT[0], 7'b1001001, PAT[9], PAT[2]);

        // Consumer stalls while digit 0 changes 5 -> 8
        rdy_mode = 0;
        frame4(PAT[5], PAT[6], PAT[7], PAT[3]);
        dwell(0, PAT[8], 20);
        dwell(-1, 7'h00, 2);
        rdy_mode = 1;
        dwell(-1, 7'h00, 3);
        frame4(PAT[8], PAT[6], PAT[7], PAT[3]);

        // All anodes active: no accepts
        dwell(-2, PAT[8], 10);
        dwell(-1, 7'h00, 3);

        // Reset while a frame is held
        rdy_mode = 0;
        frame4(PAT[1], PAT[1], PAT[1], PAT[1]);
        dwell(-1, 7'h00, 3);
        do_reset(2);
        rdy_mode = 1;

        // All-off on digit 3
        frame4(PAT[2], PAT[4], PAT[6], 7'b0000000);

        // Randomised traffic
        rdy_mode = 2;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 3));
            an = int'($urandom_range(0, N + 1)) - 2;
            if ($urandom_range(0, 4) == 0) pat = 7'($urandom);
            else                           pat = PAT[$urandom_range(0, 9)];
            if (an >= 0 && an == prev_an && pat == prev_pat) an = -1;
            dwell(an, pat, $urandom_range(1, 8));
        end
        dwell(-1, 7'h00, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
